ha_window_accum: RTL and testbench
==================================

Name: ha_window_accum

Overview:
- Downstream consumer of the I.P2 modport: samples the half-adder pair z (carry) and w (sum) driven by the upstream logic stage.
- Accumulates the 2-bit sample value over a fixed window of enabled samples.
- Presents the window total to a sink through a valid/ready handshake.
- Sits beside the plain output-forwarding stage on the same interface instance, inside top-level wrappers that carry the interface as a port.

Parameters:
- WIDTH, 8: width of the accumulator and of o_sum.
- WINDOW, 4: number of accepted samples per result. Legal range is 2..255.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- p2  interface  I.P2  upstream interface port; z and w are read only.
- i_en  input  1  sample strobe; p2.z and p2.w are accepted when high in the ACC state.
- i_clr  input  1  synchronous clear.
- i_ready  input  1  sink ready.
- o_valid  output  1  result valid.
- o_sum  output  WIDTH  window total, held while o_valid is high.
- o_ovf  output  1  saturation occurred in the presented window.
- o_drop  output  1  sticky flag: a sample arrived while results were blocked.
- o_cnt  output  8  number of samples accepted in the current window.

Behaviour:
- Sample value v = {p2.z, p2.w}, read as unsigned 2 bits: 0, 1 or 2 in normal use.
  - z=w=1 is not produced upstream. If it occurs, v=3 and the block must not error.
- Reset (i_rst_n low, asynchronous):
  - state=ACC.
  - Internal acc=0.
  - o_sum=0, o_cnt=0, o_valid=0, o_ovf=0, o_drop=0.
- States: ACC and HOLD.
- ACC state, i_en=1:
  - acc <= sat(acc+v), where sat clamps at 2^WIDTH-1 and sets an internal ovf flag on clamping.
  - o_cnt increments.
  - If o_cnt == WINDOW-1 at that edge:
    - o_sum <= sat(acc+v), o_ovf <= ovf including this sample, o_valid <= 1.
    - acc <= 0, o_cnt <= 0, state <= HOLD.
  - Latency: o_valid rises on the edge that accepts the WINDOW-th sample. The result is visible the following cycle.
- ACC state, i_en=0: all state is held.
- HOLD state:
  - o_sum, o_ovf and o_valid stay stable until the handshake.
  - i_en=1 in HOLD does not accumulate; o_drop <= 1.
  - o_valid && i_ready at an edge completes the handshake: o_valid <= 0, o_ovf <= 0, state <= ACC.
  - Any i_en in the handshake cycle is dropped, and o_drop is set.
  - Accumulation resumes on the next cycle.
- o_valid must never fall without i_ready, except on i_clr or reset.
- o_drop is sticky. It is cleared only by i_clr or reset.
- i_clr=1 has priority over everything except reset:
  - Next state is ACC.
  - acc, o_cnt, o_sum, o_valid, o_ovf and o_drop all return to 0.
  - Any sample presented that cycle is discarded.
- Asynchronous reset mid-window or mid-HOLD discards all partial state immediately. No result is emitted.
- Saturation is per window. ovf clears together with acc when a window closes.
- o_cnt never reaches WINDOW; it wraps to 0 on window completion.

Test Plan:
- Reset, then 4 samples (WINDOW=4) with i_en=1 and (z,w) = (0,1), (1,0), (0,0), (1,0), i_ready=1.
  - Expect o_valid for exactly 1 cycle, o_sum=5, o_ovf=0.
  - Then o_cnt=0 and the block is back in ACC.
- Same 4 samples with i_ready=0 for 3 cycles after o_valid, plus i_en pulses during HOLD.
  - Expect o_sum=5 stable and o_valid held for 3 cycles.
  - Expect o_drop=1 and the dropped samples excluded from the next window.
  - Raise i_ready: o_valid falls on the next edge.
- WIDTH=3, WINDOW=4, four samples with (z,w)=(1,0):
  - Expect o_sum=7 (saturated), o_ovf=1.
  - The next clean window gives o_ovf=0.
- i_clr asserted after 2 samples (o_cnt=2), then 4 samples of (0,1):
  - Expect o_cnt=0 immediately after the clear, o_sum=4 for the new window, o_drop=0.
- Drop i_rst_n asynchronously between clock edges while in HOLD with o_sum=6:
  - Expect o_valid=0 and o_sum=0 without waiting for a clock edge.
  - After release, a fresh window of 4 samples of (0,0) gives o_sum=0.
- i_en toggling every other cycle with (z,w)=(0,1):
  - Expect o_cnt to increment only on enabled cycles.
  - Expect o_valid after the 4th enabled sample (8th cycle), with o_sum=4.

Source files
------------

// File: rtl/ha_window_accum_if.sv
// ha_window_accum_if: half-adder pair interface carrying carry z and sum w
// Signals:
//   z  carry output of the upstream half adder
//   w  sum output of the upstream half adder
// Modports:
//   P1  upstream driver (drives z, w)
//   P2  downstream consumer (reads z, w)
interface I;
    logic z;
    logic w;
    modport P1 (output z, w);
    modport P2 (input z, w);
endinterface

// File: rtl/ha_window_accum.sv
// ha_window_accum: saturating accumulator of half-adder samples over a fixed window, valid/ready output
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   p2       upstream interface, z and w read only
//   i_en     sample strobe, accepted in ACC
//   i_clr    synchronous clear, highest priority after reset
//   i_ready  sink ready
//   o_valid  result valid
//   o_sum    window total, stable while o_valid
//   o_ovf    saturation occurred in the presented window
//   o_drop   sticky: a sample arrived while a result was pending
//   o_cnt    samples accepted in the current window
module ha_window_accum #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    I.P2                     p2,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_ovf,
    output logic             o_drop,
    output logic [7:0]       o_cnt
);
    typedef enum logic {ACC, HOLD} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt, sum_nxt, sat;
    logic [WIDTH:0]   sum_raw;
    logic [7:0]       cnt_nxt;
    logic             acc_ovf, acc_ovf_nxt, sat_ovf;
    logic             valid_nxt, ovf_nxt, drop_nxt;

    // One extra bit catches the carry out; clamping keeps the total at all-ones.
    assign sum_raw = {1'b0, acc} + {{(WIDTH-1){1'b0}}, p2.z, p2.w};
    assign sat     = sum_raw[WIDTH] ? '1 : sum_raw[WIDTH-1:0];
    assign sat_ovf = acc_ovf | sum_raw[WIDTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ACC;
            acc     <= '0;
            acc_ovf <= 1'b0;
            o_cnt   <= '0;
            o_sum   <= '0;
            o_valid <= 1'b0;
            o_ovf   <= 1'b0;
            o_drop  <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            acc_ovf <= acc_ovf_nxt;
            o_cnt   <= cnt_nxt;
            o_sum   <= sum_nxt;
            o_valid <= valid_nxt;
            o_ovf   <= ovf_nxt;
            o_drop  <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        acc_ovf_nxt = acc_ovf;
        cnt_nxt     = o_cnt;
        sum_nxt     = o_sum;
        valid_nxt   = o_valid;
        ovf_nxt     = o_ovf;
        drop_nxt    = o_drop;
        if (i_clr) begin
            state_nxt   = ACC;
            acc_nxt     = '0;
            acc_ovf_nxt = 1'b0;
            cnt_nxt     = '0;
            sum_nxt     = '0;
            valid_nxt   = 1'b0;
            ovf_nxt     = 1'b0;
            drop_nxt    = 1'b0;
        end else if (state == ACC) begin
            if (i_en) begin
                if (o_cnt == 8'(WINDOW - 1)) begin
                    sum_nxt     = sat;
                    ovf_nxt     = sat_ovf;
                    valid_nxt   = 1'b1;
                    acc_nxt     = '0;
                    acc_ovf_nxt = 1'b0;
                    cnt_nxt     = '0;
                    state_nxt   = HOLD;
                end else begin
                    acc_nxt     = sat;
                    acc_ovf_nxt = sat_ovf;
                    cnt_nxt     = o_cnt + 8'd1;
                end
            end
        end else begin
            // Samples cannot be taken while a result waits, including the handshake cycle.
            if (i_en)
                drop_nxt = 1'b1;
            if (o_valid && i_ready) begin
                valid_nxt = 1'b0;
                ovf_nxt   = 1'b0;
                state_nxt = ACC;
            end
        end
    end
endmodule

// File: tb/tb_ha_window_accum.sv
// tb_ha_window_accum: directed self-checking bench for ha_window_accum (WIDTH=8 and WIDTH=3 instances)
module tb_ha_window_accum;
    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_en = 1'b0;
    logic       i_clr = 1'b0;
    logic       i_ready = 1'b0;
    logic       v8, v3, f8, f3, d8, d3;
    logic [7:0] s8, c8, c3;
    logic [2:0] s3;
    int         n_cmp = 0;
    int         n_bad = 0;

    I bus ();

    always #5 i_clk = ~i_clk;

    ha_window_accum #(.WIDTH(8), .WINDOW(4)) u8 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .p2(bus), .i_en(i_en), .i_clr(i_clr),
        .i_ready(i_ready), .o_valid(v8), .o_sum(s8), .o_ovf(f8), .o_drop(d8), .o_cnt(c8)
    );

    ha_window_accum #(.WIDTH(3), .WINDOW(4)) u3 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .p2(bus), .i_en(i_en), .i_clr(i_clr),
        .i_ready(i_ready), .o_valid(v3), .o_sum(s3), .o_ovf(f3), .o_drop(d3), .o_cnt(c3)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic smp(input logic z, input logic w);
        i_en = 1'b1;
        bus.z = z;
        bus.w = w;
        tick();
        i_en = 1'b0;
    endtask

    task automatic win(input logic z, input logic w);
        for (int k = 0; k < 4; k++) smp(z, w);
    endtask

    initial begin
        bus.z = 1'b0;
        bus.w = 1'b0;
        #2;
        check("rst_valid", v8, 0);
        check("rst_sum", s8, 0);
        check("rst_cnt", c8, 0);
        check("rst_ovf", f8, 0);
        check("rst_drop", d8, 0);
        #10 i_rst_n = 1'b1;
        tick();

        // basic window, sink always ready
        i_ready = 1'b1;
        smp(0, 1); smp(1, 0); smp(0, 0);
        check("t1_cnt3", c8, 3);
        check("t1_valid_pre", v8, 0);
        smp(1, 0);
        check("t1_valid", v8, 1);
        check("t1_sum", s8, 5);
        check("t1_ovf", f8, 0);
        check("t1_cnt0", c8, 0);
        tick();
        check("t1_valid_fall", v8, 0);
        smp(0, 1);
        check("t1_back_acc", c8, 1);
        i_clr = 1'b1; tick(); i_clr = 1'b0;

        // back-pressure with samples arriving during HOLD
        i_ready = 1'b0;
        smp(0, 1); smp(1, 0); smp(0, 0); smp(1, 0);
        for (int k = 0; k < 3; k++) begin
            smp(1, 0);
            check("t2_hold_valid", v8, 1);
            check("t2_hold_sum", s8, 5);
        end
        check("t2_drop", d8, 1);
        check("t2_cnt_hold", c8, 0);
        i_ready = 1'b1;
        tick();
        check("t2_valid_fall", v8, 0);
        win(0, 1);
        check("t2_next_valid", v8, 1);
        check("t2_next_sum", s8, 4);
        check("t2_drop_sticky", d8, 1);
        tick();

        // saturation on the 3-bit instance
        i_clr = 1'b1; tick(); i_clr = 1'b0;
        check("t3_drop_clr", d8, 0);
        win(1, 0);
        check("t3_sum3", s3, 7);
        check("t3_ovf3", f3, 1);
        check("t3_sum8", s8, 8);
        check("t3_ovf8", f8, 0);
        tick();
        check("t3_ovf3_hs", f3, 0);
        win(0, 1);
        check("t3_clean_sum3", s3, 4);
        check("t3_clean_ovf3", f3, 0);
        tick();

        // illegal z=w=1 sample still accumulates as 3
        win(1, 1);
        check("t3b_sum8", s8, 12);
        check("t3b_sum3", s3, 7);
        check("t3b_ovf3", f3, 1);
        tick();

        // clear mid-window discards partial state and the sample presented with it
        smp(0, 1); smp(0, 1);
        check("t4_cnt2", c8, 2);
        i_clr = 1'b1; i_en = 1'b1; bus.z = 1'b1; bus.w = 1'b0;
        tick();
        i_clr = 1'b0; i_en = 1'b0;
        check("t4_cnt0", c8, 0);
        check("t4_valid0", v8, 0);
        win(0, 1);
        check("t4_sum", s8, 4);
        check("t4_drop", d8, 0);
        tick();

        // asynchronous reset while holding a result
        i_ready = 1'b0;
        smp(1, 0); smp(1, 0); smp(1, 0); smp(0, 0);
        check("t5_hold_sum", s8, 6);
        check("t5_hold_valid", v8, 1);
        #3 i_rst_n = 1'b0;
        #1;
        check("t5_async_valid", v8, 0);
        check("t5_async_sum", s8, 0);
        check("t5_async_cnt", c8, 0);
        #2 i_rst_n = 1'b1;
        tick();
        check("t5_post_valid", v8, 0);
        win(0, 0);
        check("t5_fresh_valid", v8, 1);
        check("t5_fresh_sum", s8, 0);
        i_ready = 1'b1;
        tick();

        // strobe every other cycle
        bus.z = 1'b0;
        bus.w = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i_en = (k % 2 == 1);
            tick();
            if (k < 7) check("t6_cnt", c8, (k + 1) / 2);
        end
        i_en = 1'b0;
        check("t6_valid", v8, 1);
        check("t6_sum", s8, 4);
        tick();
        check("t6_valid_fall", v8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
